// File: rtl/dispatch_if.sv
// Decode <-> dispatch handshake bundle.
// master: decode/issue/ROB side (drives flush, decode_vld, IQ_choose,
//         iq_release, rob_retire; observes ready/hold/write-enables/tag).
// slave : dispatch_ctrl.
// Ports carried: flush, decode_vld, IQ_choose[3:0], iq_release[3:0],
//   rob_retire[1:0], dispatch_rdy, hold_stage3, iq_wr_en[3:0],
//   rob_id[RW-1:0], iq_full[3:0], perf_stall[31:0].
interface dispatch_if #(
  parameter int ROB_DEPTH = 16
);
  localparam int RW = $clog2(ROB_DEPTH);

  logic          flush;
  logic          decode_vld;
  logic [3:0]    IQ_choose;
  logic [3:0]    iq_release;
  logic [1:0]    rob_retire;
  logic          dispatch_rdy;
  logic          hold_stage3;
  logic [3:0]    iq_wr_en;
  logic [RW-1:0] rob_id;
  logic [3:0]    iq_full;
  logic [31:0]   perf_stall;

  modport master (
    output flush, decode_vld, IQ_choose, iq_release, rob_retire,
    input  dispatch_rdy, hold_stage3, iq_wr_en, rob_id, iq_full, perf_stall
  );

  modport slave (
    input  flush, decode_vld, IQ_choose, iq_release, rob_retire,
    output dispatch_rdy, hold_stage3, iq_wr_en, rob_id, iq_full, perf_stall
  );
endinterface

// File: rtl/dispatch_ctrl.sv
// Dispatch controller between decode and the four issue queues
// (ALU0, ALU1, AGU, BRU) plus the ROB.
// Tracks per-IQ free-entry credits, ROB occupancy and tail pointer;
// back-pressures decode via hold_stage3 and restores everything on flush.
// Ports: clk, rst (sync, active-high), bus (dispatch_if.slave).
// Optional: DISPATCH_PERF_CNT_EN builds the saturating stall counter
// behind perf_stall; without it perf_stall is tied to 0.
module dispatch_ctrl #(
  parameter int IQ_DEPTH  = 8,
  parameter int ROB_DEPTH = 16
) (
  input  logic     clk,
  input  logic     rst,
  dispatch_if.slave bus
);
  localparam int NUM_IQ = 4;
  localparam int RW     = $clog2(ROB_DEPTH);
  localparam int CW     = $clog2(IQ_DEPTH + 1);
  localparam logic [CW-1:0] CRED_MAX = CW'(IQ_DEPTH);
  localparam logic [RW:0]   ROB_MAX  = (RW+1)'(ROB_DEPTH);

  typedef enum logic [1:0] {RUN, BLOCK, RECOVER} state_t;

  state_t                       state;
  logic [NUM_IQ-1:0][CW-1:0]    cred;
  logic [RW:0]                  rob_cnt;
  logic [RW-1:0]                tail;
  logic                         rdy;
  logic                         hold;
  logic                         fire;
  logic [RW:0]                  rob_sum;
  logic [RW:0]                  rob_ret;
  logic [RW:0]                  rob_cnt_n;

  // Readiness looks only at registered state: a same-cycle release never
  // unblocks a full IQ.
  assign rdy  = (state != RECOVER) && (rob_cnt < ROB_MAX) &&
                ((bus.IQ_choose & bus.iq_full) == '0);
  assign hold = bus.decode_vld & ~rdy;
  // Flush discards the same-cycle allocation.
  assign fire = bus.decode_vld & rdy & ~bus.flush;

  assign bus.dispatch_rdy = rdy;
  assign bus.hold_stage3  = hold;
  assign bus.iq_wr_en     = bus.IQ_choose & {NUM_IQ{fire}};
  assign bus.rob_id       = tail;

  for (genvar i = 0; i < NUM_IQ; i++) begin : g_cred
    logic [CW-1:0] c;
    logic [CW:0]   sum;
    // fire implies c > 0 for a selected IQ, so sum never underflows.
    assign sum = {1'b0, c} - {{CW{1'b0}}, fire & bus.IQ_choose[i]}
                           + {{CW{1'b0}}, bus.iq_release[i]};
    always_ff @(posedge clk) begin
      if (rst || bus.flush) c <= CRED_MAX;
      else if (sum > {1'b0, CRED_MAX}) c <= CRED_MAX;  // extra release ignored
      else c <= sum[CW-1:0];
    end
    assign cred[i]        = c;
    assign bus.iq_full[i] = (c == '0);
  end

  // Occupancy clamps at zero if more retires arrive than are outstanding.
  assign rob_sum   = rob_cnt + {{RW{1'b0}}, fire};
  assign rob_ret   = {{(RW-1){1'b0}}, bus.rob_retire};
  assign rob_cnt_n = (rob_sum < rob_ret) ? '0 : rob_sum - rob_ret;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RUN;
      rob_cnt <= '0;
      tail    <= '0;
    end else if (bus.flush) begin
      state   <= RECOVER;
      rob_cnt <= '0;
      tail    <= '0;
    end else begin
      rob_cnt <= rob_cnt_n;
      if (fire) tail <= tail + 1'b1;  // power-of-2 depth: natural wrap
      case (state)
        RUN:     if (hold)  state <= BLOCK;
        BLOCK:   if (!hold) state <= RUN;
        RECOVER: state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

`ifdef DISPATCH_PERF_CNT_EN
  logic [31:0] perf;
  always_ff @(posedge clk) begin
    if (rst) perf <= '0;
    else if (hold && (perf != 32'hFFFF_FFFF)) perf <= perf + 32'd1;
  end
  assign bus.perf_stall = perf;
`else
  assign bus.perf_stall = '0;
`endif
endmodule

// File: tb/tb_dispatch_ctrl.sv
// Self-checking bench for dispatch_ctrl: vector table applied cycle by
// cycle, expected outputs queued at drive time and popped at sample time.
module tb_dispatch_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dispatch_if #(.ROB_DEPTH(16)) bus();
  dispatch_ctrl #(.IQ_DEPTH(8), .ROB_DEPTH(16)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic       fl;
    logic       vld;
    logic [3:0] ch;
    logic [3:0] rel;
    logic [1:0] ret;
    logic       rdy;
    logic       hold;
    logic [3:0] wr;
    logic [3:0] id;
    logic [3:0] full;
  } vec_t;

  vec_t        tbl[$];
  vec_t        exp_q[$];
  int          n_pass = 0;
  int          n_tot  = 0;
  logic [31:0] exp_perf = 0;

  function automatic vec_t mk(logic fl, logic vld, logic [3:0] ch, logic [3:0] rel,
                              logic [1:0] ret, logic rdy, logic hold, logic [3:0] wr,
                              logic [3:0] id, logic [3:0] full);
    vec_t v;
    v.fl = fl; v.vld = vld; v.ch = ch; v.rel = rel; v.ret = ret;
    v.rdy = rdy; v.hold = hold; v.wr = wr; v.id = id; v.full = full;
    return v;
  endfunction

  task automatic chk(string nm, int step, logic [31:0] act, logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s step %0d: got %0h expected %0h", nm, step, act, exp);
    else n_pass++;
  endtask

  task automatic apply(vec_t v, int step);
    vec_t e;
    @(posedge clk); #1;
    bus.flush      = v.fl;
    bus.decode_vld = v.vld;
    bus.IQ_choose  = v.ch;
    bus.iq_release = v.rel;
    bus.rob_retire = v.ret;
    exp_q.push_back(v);
    @(negedge clk);
    e = exp_q.pop_front();
    chk("dispatch_rdy", step, {31'b0, bus.dispatch_rdy}, {31'b0, e.rdy});
    chk("hold_stage3",  step, {31'b0, bus.hold_stage3},  {31'b0, e.hold});
    chk("iq_wr_en",     step, {28'b0, bus.iq_wr_en},     {28'b0, e.wr});
    chk("rob_id",       step, {28'b0, bus.rob_id},       {28'b0, e.id});
    chk("iq_full",      step, {28'b0, bus.iq_full},      {28'b0, e.full});
    chk("perf_stall",   step, bus.perf_stall,            exp_perf);
`ifdef DISPATCH_PERF_CNT_EN
    if (e.hold && exp_perf != 32'hFFFF_FFFF) exp_perf = exp_perf + 1;
`endif
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    bus.flush = 0; bus.decode_vld = 0; bus.IQ_choose = 0;
    bus.iq_release = 0; bus.rob_retire = 0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    exp_perf = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.flush = 0; bus.decode_vld = 0; bus.IQ_choose = 0;
    bus.iq_release = 0; bus.rob_retire = 0;

    // Reset state, ALU0 fill, no-bypass release, flush/recover, multi-hot.
    tbl.push_back(mk(0,0,4'h0,4'h0,0, 1,0,4'h0,4'd0,4'h0));
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(0,1,4'h1,4'h0,0, 1,0,4'h1,4'(i),4'h0));
    tbl.push_back(mk(0,1,4'h1,4'h0,0, 0,1,4'h0,4'd8,4'h1));
    tbl.push_back(mk(0,1,4'h1,4'h1,0, 0,1,4'h0,4'd8,4'h1));  // release: no bypass
    tbl.push_back(mk(0,1,4'h1,4'h0,0, 1,0,4'h1,4'd8,4'h0));
    tbl.push_back(mk(0,0,4'h0,4'h0,0, 1,0,4'h0,4'd9,4'h1));  // full again
    tbl.push_back(mk(0,1,4'h6,4'h0,0, 1,0,4'h6,4'd9,4'h1));
    tbl.push_back(mk(0,1,4'h8,4'h0,0, 1,0,4'h8,4'd10,4'h1));
    tbl.push_back(mk(1,1,4'h2,4'hF,2, 1,0,4'h0,4'd11,4'h1)); // flush: wr forced 0
    tbl.push_back(mk(0,1,4'h0,4'h0,0, 0,1,4'h0,4'd0,4'h0));  // RECOVER
    tbl.push_back(mk(0,0,4'h0,4'h0,0, 1,0,4'h0,4'd0,4'h0));
    tbl.push_back(mk(1,1,4'h1,4'h0,0, 1,0,4'h0,4'd0,4'h0));
    tbl.push_back(mk(1,0,4'h0,4'h0,0, 0,0,4'h0,4'd0,4'h0));  // flush in RECOVER
    tbl.push_back(mk(0,1,4'h1,4'h0,0, 0,1,4'h0,4'd0,4'h0));  // still RECOVER
    tbl.push_back(mk(0,1,4'h1,4'h0,0, 1,0,4'h1,4'd0,4'h0));
    tbl.push_back(mk(0,1,4'hF,4'h0,0, 1,0,4'hF,4'd1,4'h0));  // multi-hot

    do_reset();
    foreach (tbl[k]) apply(tbl[k], k);

    // AGU release at full credit must saturate: exactly 8 fires fit.
    apply(mk(1,0,4'h0,4'h0,0, 1,0,4'h0,4'd2,4'h0), 100);
    apply(mk(0,0,4'h0,4'h0,0, 0,0,4'h0,4'd0,4'h0), 101);
    apply(mk(0,0,4'h0,4'h4,0, 1,0,4'h0,4'd0,4'h0), 102);
    apply(mk(0,0,4'h0,4'h4,0, 1,0,4'h0,4'd0,4'h0), 103);
    for (int i = 0; i < 8; i++)
      apply(mk(0,1,4'h4,4'h0,0, 1,0,4'h4,4'(i),4'h0), 110 + i);
    apply(mk(0,1,4'h4,4'h0,0, 0,1,4'h0,4'd8,4'h4), 120);
    apply(mk(0,1,4'h1,4'h0,0, 1,0,4'h1,4'd8,4'h4), 121);    // other IQ unaffected

    // ROB fill, full stall, retire, tail wrap.
    apply(mk(1,0,4'h0,4'h0,0, 1,0,4'h0,4'd9,4'h4), 200);
    apply(mk(0,0,4'h0,4'h0,0, 0,0,4'h0,4'd0,4'h0), 201);
    for (int i = 0; i < 16; i++)
      apply(mk(0,1,4'h0,4'h0,0, 1,0,4'h0,4'(i),4'h0), 210 + i);
    apply(mk(0,1,4'h0,4'h0,0, 0,1,4'h0,4'd0,4'h0), 230);
    apply(mk(0,1,4'h0,4'h0,0, 0,1,4'h0,4'd0,4'h0), 231);
    apply(mk(0,1,4'h0,4'h0,2, 0,1,4'h0,4'd0,4'h0), 232);    // retire 2
    apply(mk(0,1,4'h0,4'h0,0, 1,0,4'h0,4'd0,4'h0), 233);    // fire, rob_id wraps to 0

    // Retire at empty ROB clamps at zero.
    apply(mk(1,0,4'h0,4'h0,0, 1,0,4'h0,4'd1,4'h0), 300);
    apply(mk(0,0,4'h0,4'h0,0, 0,0,4'h0,4'd0,4'h0), 301);
    apply(mk(0,0,4'h0,4'h0,2, 1,0,4'h0,4'd0,4'h0), 302);
    apply(mk(0,1,4'h0,4'h0,0, 1,0,4'h0,4'd0,4'h0), 303);

    // Stall counting across a flush, then cleared by rst.
    apply(mk(1,0,4'h0,4'h0,0, 1,0,4'h0,4'd1,4'h0), 400);
    for (int i = 0; i < 5; i++) begin
      apply(mk(0,1,4'h0,4'h0,0, 0,1,4'h0,4'd0,4'h0), 410 + i);
      if (i < 4) apply(mk(1,0,4'h0,4'h0,0, 1,0,4'h0,4'd0,4'h0), 420 + i);
    end
    apply(mk(0,0,4'h0,4'h0,0, 1,0,4'h0,4'd0,4'h0), 430);
    do_reset();
    apply(mk(0,0,4'h0,4'h0,0, 1,0,4'h0,4'd0,4'h0), 500);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
